// File: rtl/cla_seq_ctrl.sv
// Sequential adder that time-shares one 4-bit carry-lookahead adder over
// NIBBLES nibbles, least significant nibble first.
// `define CLA_SEQ_SUB_EN adds a 'sub' input that computes a + ~b + 1 instead.

// 4-bit carry-lookahead adder: all four carries computed from generate/propagate.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Flattened lookahead carry equations
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[3:0];
        cout = c[4];
    end

endmodule

module cla_seq_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;

    logic [3:0]    cla_a, cla_b, cla_s;
    logic          cla_co;
    logic          do_sub;

`ifdef CLA_SEQ_SUB_EN
    assign do_sub = sub;
`else
    assign do_sub = 1'b0;
`endif

    // Current nibble of the latched operands feeds the shared adder
    always_comb begin
        cla_a = a_q[{idx_q, 2'b00} +: 4];
        cla_b = b_q[{idx_q, 2'b00} +: 4];
    end

    cla4 u_cla4 (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (carry_q),
        .s    (cla_s),
        .cout (cla_co)
    );

    // Next-state: accept start outside RUN, step one nibble per RUN cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    // Subtract is a + ~b + 1; the inversion is folded into the latch
                    b_d     = do_sub ? ~b : b;
                    carry_d = do_sub ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = StRun;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sum_d[{idx_q, 2'b00} +: 4] = cla_s;
                carry_d = cla_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = cla_co;
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Status and result outputs straight from registers
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl (default NIBBLES=4).
module tb_cla_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef CLA_SEQ_SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    int checks;
    int failures;

    cla_seq_ctrl #(
        .NIBBLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One start pulse, then wait for done; checks latency, busy length and result
    task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] esum, input logic ecout);
        int lat;
        int bcnt;
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_busy_cycles"}, bcnt, 4);
        check({tag, "_sum"}, {16'h0, sum}, {16'h0, esum});
        check({tag, "_cout"}, {31'h0, cout}, {31'h0, ecout});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
        check({tag, "_sum_held"}, {16'h0, sum}, {16'h0, esum});
    endtask

    initial begin
        int dcnt;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        #12;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_sum", {16'h0, sum}, 32'h0);
        check("rst_cout", {31'h0, cout}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        do_op("ripple_b1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        do_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        do_op("msb_carry", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        do_op("mixed_cin", 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0);

        // start during RUN must be ignored
        @(negedge clk);
        a = 16'h0102; b = 16'h0304; cin = 1'b0; start = 1'b1;
        @(negedge clk);              // RUN cycle 1
        start = 1'b0;
        @(negedge clk);              // RUN cycle 2
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);              // RUN cycle 3
        a = 16'h7777; b = 16'h1111;
        @(negedge clk);              // RUN cycle 4
        start = 1'b0;
        check("ign_busy", {31'h0, busy}, 32'h1);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                check("ign_sum", {16'h0, sum}, 32'h0406);
                check("ign_cout", {31'h0, cout}, 32'h0);
            end
        end
        check("ign_done_count", dcnt, 1);

        // reset in the middle of RUN (idx=2)
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);              // two RUN edges done, idx=2
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_sum", {16'h0, sum}, 32'h0);
        check("mid_rst_cout", {31'h0, cout}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("post_rst_quiet", dcnt, 0);

        // start held through DONE: back-to-back operations
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001;  // still high, ignored until DONE
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);              // DONE
        check("b2b_done1", {31'h0, done}, 32'h1);
        check("b2b_sum1", {16'h0, sum}, 32'h5555);
        @(negedge clk);
        start = 1'b0;
        check("b2b_rerun_busy", {31'h0, busy}, 32'h1);
        check("b2b_rerun_done", {31'h0, done}, 32'h0);
        check("b2b_sum_clear", {16'h0, sum}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("b2b_not_yet", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("b2b_done2", {31'h0, done}, 32'h1);
        check("b2b_sum2", {16'h0, sum}, 32'h0002);
        check("b2b_cout2", {31'h0, cout}, 32'h0);
        @(negedge clk);
        check("b2b_idle", {31'h0, done | busy}, 32'h0);

`ifdef CLA_SEQ_SUB_EN
        sub = 1'b1;
        do_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        do_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
        sub = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
